// File: rtl/adder_pkg.sv
// Purpose: shared constants and parameter legality check for the pipelined adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Legal when the word splits into equal, non-empty slices.
  function automatic bit params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Purpose: operand/result handshake bundle of the pipelined adder.
// Latency: n/a (wires only).
// Backpressure: ready_i (consumer) and ready_o (producer) travel with the bundle.
// Ports: valid_i/ready_o/a_i/b_i/cin_i/sub_i on the issue side,
//        valid_o/ready_i/sum_o/cout_o/ovf_o/zero_o on the result side.
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;

  // Adder side.
  modport slave (
    input  valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    output ready_o, valid_o, sum_o, cout_o, ovf_o, zero_o
  );

  // Issue logic / result consumer side.
  modport master (
    output valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    input  ready_o, valid_o, sum_o, cout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/adder_stage.sv
// Purpose: one SLICE-wide ripple slice of the skewed adder pipeline, plus its valid bit.
// Latency: 1 cycle (registered payload and valid).
// Backpressure: holds its token while rdy_i is low; rdy_i is this stage's own ready.
// Ports: vld_i/rdy_i/vld_o handshake; a_i/b_i/c_i/z_i skewed payload in, a_o/b_o/c_o/z_o out;
//        ovf_o is only produced by the last stage (K == STAGES-1), tied low elsewhere.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int K      = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic             rdy_i,
  output logic             vld_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             z_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             c_o,
  output logic             z_o,
  output logic             ovf_o
);
  localparam int SLICE = WIDTH / STAGES;

  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             w_load;

  logic             r_vld;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic             r_z;

  // The slice being summed always sits in the low SLICE bits.
  assign {w_cout, w_sum} = {1'b0, a_i[SLICE-1:0]} + {1'b0, b_i[SLICE-1:0]}
                         + {{SLICE{1'b0}}, c_i};

  // A rotates: the finished slice enters at the top, so after STAGES stages
  // the A lane holds the complete sum in natural bit order. B just shifts out.
  if (STAGES == 1) begin : g_single
    assign w_a_nxt = w_sum;
    assign w_b_nxt = '0;
  end else begin : g_rotate
    assign w_a_nxt = {w_sum, a_i[WIDTH-1:SLICE]};
    assign w_b_nxt = {{SLICE{1'b0}}, b_i[WIDTH-1:SLICE]};
  end

  assign w_load = rdy_i && vld_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_z   <= 1'b0;
    end else begin
      if (rdy_i) r_vld <= vld_i;
      if (w_load) begin
        r_a <= w_a_nxt;
        r_b <= w_b_nxt;
        r_c <= w_cout;
        r_z <= z_i && (w_sum == '0);
      end
    end
  end

  // Signed overflow only means something at the word MSB, i.e. in the top slice.
  if (K == STAGES - 1) begin : g_ovf
    logic w_cmsb;
    logic r_ovf;
    assign w_cmsb = a_i[SLICE-1] ^ b_i[SLICE-1] ^ w_sum[SLICE-1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     r_ovf <= 1'b0;
      else if (w_load) r_ovf <= w_cmsb ^ w_cout;
    end
    assign ovf_o = r_ovf;
  end else begin : g_no_ovf
    assign ovf_o = 1'b0;
  end

  assign vld_o = r_vld;
  assign a_o   = r_a;
  assign b_o   = r_b;
  assign c_o   = r_c;
  assign z_o   = r_z;
endmodule

// File: rtl/pipelined_adder.sv
// Purpose: STAGES-deep pipelined two's-complement add/subtract with carry, overflow and zero flags.
// Latency: STAGES cycles from input transfer to valid_o; one result per cycle when unstalled.
// Backpressure: per-stage valid/ready, bubbles collapse; ready_o drops only when every stage is full.
// Ports: clk_i, rst_ni (async, active-low); bus = pipelined_adder_if slave (operands in, result out).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic               clk_i,
  input logic               rst_ni,
  pipelined_adder_if.slave  bus
);
  if (!params_ok(WIDTH, STAGES)) begin : g_param_err
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Skewed payload carried between stages.
  typedef struct packed {
    logic [WIDTH-1:0] a;   // unsummed A slices (low) + finished sum slices (high)
    logic [WIDTH-1:0] b;   // unsummed effective-B slices, low aligned
    logic             c;   // carry into the next slice
    logic             z;   // all finished slices were zero
  } pay_t;

  pay_t [STAGES:0]    w_pay;
  logic [STAGES-1:0]  w_sv;     // registered valid of each stage
  logic [STAGES:0]    w_rdy;
  logic [STAGES-1:0]  w_ovf;
  logic               w_unused;

  // Subtract is A + ~B + 1; cin is ignored then.
  assign w_pay[0] = '{a: bus.a_i,
                      b: bus.b_i ^ {WIDTH{bus.sub_i}},
                      c: bus.sub_i | bus.cin_i,
                      z: 1'b1};

  // ready[k] = !valid[k] || ready[k+1], evaluated in one process so the
  // only combinational handshake path is ready_i -> ready_o.
  always_comb begin
    w_rdy         = '0;
    w_rdy[STAGES] = bus.ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = !w_sv[k] || w_rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic w_vin;
    if (k == 0) begin : g_first
      assign w_vin = bus.valid_i;
    end else begin : g_next
      assign w_vin = w_sv[k-1];
    end

    adder_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .K      (k)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .vld_i  (w_vin),
      .rdy_i  (w_rdy[k]),
      .vld_o  (w_sv[k]),
      .a_i    (w_pay[k].a),
      .b_i    (w_pay[k].b),
      .c_i    (w_pay[k].c),
      .z_i    (w_pay[k].z),
      .a_o    (w_pay[k+1].a),
      .b_o    (w_pay[k+1].b),
      .c_o    (w_pay[k+1].c),
      .z_o    (w_pay[k+1].z),
      .ovf_o  (w_ovf[k])
    );
  end

  assign bus.ready_o = w_rdy[0];
  assign bus.valid_o = w_sv[STAGES-1];
  assign bus.sum_o   = w_pay[STAGES].a;
  assign bus.cout_o  = w_pay[STAGES].c;
  assign bus.zero_o  = w_pay[STAGES].z;
  assign bus.ovf_o   = w_ovf[STAGES-1];

  // B residue after the last slice and the non-final stages' ovf ties have no consumer.
  assign w_unused = ^{w_pay[STAGES].b, w_ovf};
endmodule

// File: tb/tb_pipelined_adder.sv
// Purpose: directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// Latency: expects results exactly 4 cycles after acceptance.
// Backpressure: exercises full-pipeline stall, release, and mid-stream reset.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus ();

  pipelined_adder #(
    .WIDTH  (32),
    .STAGES (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated token on an empty pipeline, consumer always ready.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] e_sum,
                         input logic e_cout, input logic e_ovf, input logic e_zero);
    @(negedge clk);
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.cin_i   = cin;
    bus.sub_i   = sub;
    chk({tag, "_rdy"}, bus.ready_o, 1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_early"}, bus.valid_o, 0);
    @(negedge clk);
    chk({tag, "_vld"},  bus.valid_o, 1);
    chk({tag, "_sum"},  bus.sum_o,   e_sum);
    chk({tag, "_cout"}, bus.cout_o,  e_cout);
    chk({tag, "_ovf"},  bus.ovf_o,   e_ovf);
    chk({tag, "_zero"}, bus.zero_o,  e_zero);
    @(negedge clk);
    chk({tag, "_gone"}, bus.valid_o, 0);
  endtask

  logic [31:0] bp_exp [6];
  int          in_n;
  int          out_n;

  initial begin
    bp_exp = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008,
               32'h0000_100C, 32'h0000_1010, 32'h0000_1014};
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.cin_i   = 1'b0;
    bus.sub_i   = 1'b0;

    // Reset state
    #1;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_sum",   bus.sum_o,   0);
    chk("rst_cout",  bus.cout_o,  0);
    chk("rst_ovf",   bus.ovf_o,   0);
    chk("rst_zero",  bus.zero_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", bus.ready_o, 1);

    // Directed single vectors
    run_one("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("cin_add", 32'h0000_FFFF, 32'h0001_0000, 1'b1, 1'b0, 32'h0002_0000, 1'b0, 1'b0, 1'b0);
    run_one("cin_ign_sub", 32'd9, 32'd4, 1'b1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream: token c issued at negedge c appears at negedge c+4
    bus.ready_i = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c >= 4 && c < 12) begin
        chk($sformatf("stream_vld%0d", c), bus.valid_o, 1);
        chk($sformatf("stream_sum%0d", c), bus.sum_o, 32'h101 * (c - 4));
      end else begin
        chk($sformatf("stream_idle%0d", c), bus.valid_o, 0);
      end
      chk($sformatf("stream_rdy%0d", c), bus.ready_o, 1);
      if (c < 8) begin
        bus.valid_i = 1'b1;
        bus.a_i     = c;
        bus.b_i     = c << 8;
        bus.cin_i   = 1'b0;
        bus.sub_i   = 1'b0;
      end else begin
        bus.valid_i = 1'b0;
      end
    end

    // Backpressure: consumer stalled, pipeline fills after 4 accepts
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.a_i     = 32'h1000 + i;
      bus.b_i     = 3 * i;
      chk($sformatf("bp_rdy%0d", i), bus.ready_o, (i < 4) ? 1 : 0);
    end
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      chk($sformatf("bp_hold_vld%0d", s), bus.valid_o, 1);
      chk($sformatf("bp_hold_sum%0d", s), bus.sum_o, 32'h0000_1000);
      chk($sformatf("bp_hold_cout%0d", s), bus.cout_o, 0);
      chk($sformatf("bp_hold_rdy%0d", s), bus.ready_o, 0);
    end
    bus.ready_i = 1'b1;
    in_n  = 4;
    out_n = 0;
    for (int c = 0; c < 30 && out_n < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.valid_o) begin
        chk($sformatf("bp_out%0d", out_n), bus.sum_o, bp_exp[out_n]);
        out_n++;
      end
      if (in_n < 6) begin
        bus.valid_i = 1'b1;
        bus.a_i     = 32'h1000 + in_n;
        bus.b_i     = 3 * in_n;
        if (bus.ready_o) in_n++;
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    chk("bp_count", out_n, 6);
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("bp_drained", bus.valid_o, 0);

    // Reset mid-stream with three tokens in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.a_i     = 32'h11 * (i + 1);
      bus.b_i     = 32'h1;
      bus.cin_i   = 1'b0;
      bus.sub_i   = 1'b0;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_pre_vld", bus.valid_o, 1);
    chk("mid_pre_sum", bus.sum_o, 32'h12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  bus.valid_o, 0);
    chk("mid_rst_sum",  bus.sum_o,   0);
    chk("mid_rst_cout", bus.cout_o,  0);
    chk("mid_rst_ovf",  bus.ovf_o,   0);
    chk("mid_rst_zero", bus.zero_o,  0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy", bus.ready_o, 1);
    run_one("post_rst", 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
